// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the core and a debug master share one single-port memory.
// The core has fixed priority, and a starvation guard forces a debug grant after STARVE_LIMIT denials.

module dmem_arbiter_rsp #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  vld,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata
);
  assign rvalid = vld;
  assign rdata  = vld ? m_rdata : '0;
endmodule

module dmem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    c_req,
  input  logic                    c_we,
  input  logic [ADDR_WIDTH-1:0]   c_addr,
  input  logic [DATA_WIDTH-1:0]   c_wdata,
  input  logic [DATA_WIDTH/8-1:0] c_be,
  output logic                    c_gnt,
  output logic                    c_rvalid,
  output logic [DATA_WIDTH-1:0]   c_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    m_en,
  output logic                    m_we,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_be,
  input  logic [DATA_WIDTH-1:0]   m_rdata
);
  localparam int BW = DATA_WIDTH/8;
  localparam int NP = 2;
  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT+1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_TRIG = CW'((STARVE_LIMIT > 0) ? STARVE_LIMIT-1 : 0);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BW-1:0]         be;
  } req_t;

  typedef enum logic {ARB, FORCE_DBG} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [NP-1:0]        gnt;
  logic [NP-1:0]        rd_iss, rd_pend;
  req_t [NP-1:0]        rq;
  req_t                 sel;
  logic [NP-1:0]        rvalid;
  logic [NP-1:0][DATA_WIDTH-1:0] rdata;

  // port 0 = core, port 1 = debug
  assign rq[0] = {c_we, c_addr, c_wdata, c_be};
  assign rq[1] = {d_we, d_addr, d_wdata, d_be};

  always_comb begin
    gnt       = '0;
    state_nxt = state;
    cnt_nxt   = cnt;
    if (rst) begin
      case (state)
        ARB:       if (c_req) gnt = 2'b01; else if (d_req) gnt = 2'b10;
        FORCE_DBG: if (d_req) gnt = 2'b10; else if (c_req) gnt = 2'b01;
        default:   gnt = '0;
      endcase
      if (d_req && !gnt[1]) cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
      else                  cnt_nxt = '0;
      if (state == ARB && STARVE_LIMIT != 0 && d_req && !gnt[1] && cnt == CNT_TRIG)
        state_nxt = FORCE_DBG;
      if (state == FORCE_DBG && (gnt[1] || !d_req))
        state_nxt = ARB;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ARB;
      cnt     <= '0;
      rd_pend <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rd_pend <= rd_iss;
    end
  end

  // rd_pend is one-hot per port, so it doubles as the registered read owner
  assign rd_iss = gnt & ~{d_we, c_we};

  always_comb begin
    sel     = gnt[1] ? rq[1] : rq[0];
    m_en    = |gnt;
    m_we    = |gnt & sel.we;
    m_addr  = rst ? sel.addr  : '0;
    m_wdata = rst ? sel.wdata : '0;
    m_be    = rst ? sel.be    : '0;
  end

  for (genvar i = 0; i < NP; i++) begin : g_rsp
    dmem_arbiter_rsp #(.DATA_WIDTH(DATA_WIDTH)) u_rsp (
      .vld     (rd_pend[i]),
      .m_rdata (m_rdata),
      .rvalid  (rvalid[i]),
      .rdata   (rdata[i])
    );
  end

  assign c_gnt    = gnt[0];
  assign d_gnt    = gnt[1];
  assign c_rvalid = rvalid[0];
  assign d_rvalid = rvalid[1];
  assign c_rdata  = rdata[0];
  assign d_rdata  = rdata[1];
endmodule
